// File: rtl/fifodoutmc_pkg.sv
// Shared helpers for the multi-channel prefetch FIFO.
// Occupancy slice width and packed-bus slice offsets.
package fifodoutmc_pkg;

  // Occupancy spans 0..LENGTH+1, so one bit wider than the address.
  function automatic int lenw(input int addrbit);
    return addrbit + 1;
  endfunction

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/fifodoutmc_fifoch_core.sv
// One FIFO channel: memory + prefetched output register, flush, sticky flags.
// Write-to-output 2 edges on an empty channel; writes drop when memory is full.
module fifoch_core
  import fifodoutmc_pkg::*;
#(
  parameter int ADDRBIT = 4,
  parameter int LENGTH  = 16,
  parameter int WIDTH   = 8,
  parameter int AFULL   = 12
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd,
  input  logic                       flush,
  input  logic                       errclr,
  output logic [WIDTH-1:0]           dout,
  output logic                       notempty,
  output logic                       full,
  output logic                       afull,
  output logic [lenw(ADDRBIT)-1:0]   len,
  output logic                       ovf,
  output logic                       udf
);

  localparam int LW = lenw(ADDRBIT);
  localparam logic [LW-1:0]      C_ONE    = LW'(1);
  localparam logic [LW-1:0]      C_LENGTH = LW'(LENGTH);
  localparam logic [LW-1:0]      C_AFULL  = LW'(AFULL);
  localparam logic [ADDRBIT-1:0] C_AINC   = ADDRBIT'(1);

  logic [WIDTH-1:0]   r_mem [LENGTH];
  logic [ADDRBIT-1:0] r_wrcnt;
  logic [LW-1:0]      r_mlen;
  logic [LW-1:0]      r_len;
  logic [WIDTH-1:0]   r_dout;
  logic               r_notempty;
  logic               r_ovf;
  logic               r_udf;

  logic               w_full;
  logic               w_wr;
  logic               w_pre;
  logic               w_pop;
  logic [ADDRBIT-1:0] w_rdcnt;
  logic               w_ovf_set;
  logic               w_udf_set;

  // Full is judged on the pre-edge mlen, so a pop cannot make room for a same-cycle write.
  assign w_full    = (r_mlen == C_LENGTH);
  assign w_wr      = wr_en & ~flush & ~w_full;
  assign w_pre     = (r_mlen != '0) & (~r_notempty | rd);
  assign w_pop     = rd & r_notempty;
  assign w_rdcnt   = r_wrcnt - r_mlen[ADDRBIT-1:0];
  assign w_ovf_set = wr_en & w_full & ~flush;
  assign w_udf_set = rd & ~r_notempty & ~flush;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wrcnt] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_ || flush) begin
      r_wrcnt    <= '0;
      r_mlen     <= '0;
      r_len      <= '0;
      r_dout     <= '0;
      r_notempty <= 1'b0;
    end else begin
      if (w_wr) r_wrcnt <= r_wrcnt + C_AINC;

      case ({w_wr, w_pre})
        2'b10:   r_mlen <= r_mlen + C_ONE;
        2'b01:   r_mlen <= r_mlen - C_ONE;
        default: r_mlen <= r_mlen;
      endcase

      case ({w_wr, w_pop})
        2'b10:   r_len <= r_len + C_ONE;
        2'b01:   r_len <= r_len - C_ONE;
        default: r_len <= r_len;
      endcase

      if (w_pre) begin
        r_dout     <= r_mem[w_rdcnt];
        r_notempty <= 1'b1;
      end else if (w_pop) begin
        r_notempty <= 1'b0;
      end
    end
  end

  // A set event in the errclr cycle wins.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~errclr);
      r_udf <= w_udf_set | (r_udf & ~errclr);
    end
  end

  assign dout     = r_dout;
  assign notempty = r_notempty;
  assign full     = w_full;
  assign afull    = (r_len >= C_AFULL);
  assign len      = r_len;
  assign ovf      = r_ovf;
  assign udf      = r_udf;

endmodule

// File: rtl/fifodoutmc.sv
// Multi-channel prefetch FIFO: shared channel-addressed write port, independent readers.
// 2-edge write-to-output latency; full channels and out-of-range channels drop writes.
module fifodoutmc
  import fifodoutmc_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CHBIT   = 2,
  parameter int ADDRBIT = 4,
  parameter int LENGTH  = 16,
  parameter int WIDTH   = 8,
  parameter int AFULL   = 12
) (
  input  logic                             clk,
  input  logic                             rst_,
  input  logic                             fifowr,
  input  logic [CHBIT-1:0]                 fifowrch,
  input  logic [WIDTH-1:0]                 fifodin,
  input  logic [NCH-1:0]                   fiford,
  input  logic [NCH-1:0]                   fifoflush,
  input  logic                             errclr,
  output logic [NCH*WIDTH-1:0]             fifodout,
  output logic [NCH-1:0]                   notempty,
  output logic [NCH-1:0]                   fifofull,
  output logic [NCH-1:0]                   fifoafull,
  output logic [NCH*lenw(ADDRBIT)-1:0]     fifolen,
  output logic [NCH-1:0]                   fifoovf,
  output logic [NCH-1:0]                   fifoudf
);

  localparam int LW = lenw(ADDRBIT);

  logic [NCH-1:0] w_wren;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    // Only indices below NCH ever match, so out-of-range writes vanish here.
    assign w_wren[c] = fifowr & (fifowrch == CHBIT'(c));

    fifoch_core #(
      .ADDRBIT (ADDRBIT),
      .LENGTH  (LENGTH),
      .WIDTH   (WIDTH),
      .AFULL   (AFULL)
    ) u_core (
      .clk      (clk),
      .rst_     (rst_),
      .wr_en    (w_wren[c]),
      .din      (fifodin),
      .rd       (fiford[c]),
      .flush    (fifoflush[c]),
      .errclr   (errclr),
      .dout     (fifodout[slice_lo(c, WIDTH) +: WIDTH]),
      .notempty (notempty[c]),
      .full     (fifofull[c]),
      .afull    (fifoafull[c]),
      .len      (fifolen[slice_lo(c, LW) +: LW]),
      .ovf      (fifoovf[c]),
      .udf      (fifoudf[c])
    );
  end

endmodule

// File: tb/tb_fifodoutmc.sv
// Directed bench for fifodoutmc: main 4-channel instance plus a 3-channel
// instance for the out-of-range write channel case.
module tb_fifodoutmc;

  logic        clk = 1'b0;
  logic        rst_;
  logic        fifowr;
  logic [1:0]  fifowrch;
  logic [7:0]  fifodin;
  logic [3:0]  fiford;
  logic [3:0]  fifoflush;
  logic        errclr;
  logic [31:0] fifodout;
  logic [3:0]  notempty, fifofull, fifoafull, fifoovf, fifoudf;
  logic [19:0] fifolen;

  logic        d3_wr;
  logic [1:0]  d3_wrch;
  logic [7:0]  d3_din;
  logic [2:0]  d3_rd, d3_flush;
  logic        d3_errclr;
  logic [23:0] d3_dout;
  logic [2:0]  d3_notempty, d3_full, d3_afull, d3_ovf, d3_udf;
  logic [14:0] d3_len;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifodoutmc #(.NCH(4), .CHBIT(2), .ADDRBIT(4), .LENGTH(16), .WIDTH(8), .AFULL(12)) dut (
    .clk(clk), .rst_(rst_), .fifowr(fifowr), .fifowrch(fifowrch), .fifodin(fifodin),
    .fiford(fiford), .fifoflush(fifoflush), .errclr(errclr), .fifodout(fifodout),
    .notempty(notempty), .fifofull(fifofull), .fifoafull(fifoafull), .fifolen(fifolen),
    .fifoovf(fifoovf), .fifoudf(fifoudf)
  );

  fifodoutmc #(.NCH(3), .CHBIT(2), .ADDRBIT(4), .LENGTH(16), .WIDTH(8), .AFULL(12)) dut3 (
    .clk(clk), .rst_(rst_), .fifowr(d3_wr), .fifowrch(d3_wrch), .fifodin(d3_din),
    .fiford(d3_rd), .fifoflush(d3_flush), .errclr(d3_errclr), .fifodout(d3_dout),
    .notempty(d3_notempty), .fifofull(d3_full), .fifoafull(d3_afull), .fifolen(d3_len),
    .fifoovf(d3_ovf), .fifoudf(d3_udf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] d);
    fifowr = 1'b1; fifowrch = ch; fifodin = d;
    step();
    fifowr = 1'b0;
  endtask

  initial begin
    int sent, got, cyc;
    rst_ = 1'b0; fifowr = 0; fifowrch = 0; fifodin = 0; fiford = 0; fifoflush = 0; errclr = 0;
    d3_wr = 0; d3_wrch = 0; d3_din = 0; d3_rd = 0; d3_flush = 0; d3_errclr = 0;

    // Reset state
    step(); step();
    check("rst_dout", fifodout, 32'h0);
    check("rst_notempty", {28'h0, notempty}, 32'h0);
    check("rst_len", {12'h0, fifolen}, 32'h0);
    check("rst_flags", {16'h0, fifofull, fifoafull, fifoovf, fifoudf}, 32'h0);
    rst_ = 1'b1;
    step(); step();

    // Basic latency on ch2
    wr(2'd2, 8'hA5);
    check("lat_edge1_notempty", {28'h0, notempty}, 32'h0);
    step();
    check("lat_edge2_notempty", {28'h0, notempty}, 32'h4);
    check("lat_dout2", {24'h0, fifodout[16 +: 8]}, 32'hA5);
    check("lat_len2", {27'h0, fifolen[10 +: 5]}, 32'd1);
    fifoflush = 4'b0100; step(); fifoflush = 0;

    // Fill ch0 to LENGTH+1, then overflow
    for (int i = 0; i < 17; i++) wr(2'd0, 8'(i));
    check("fill_len0", {27'h0, fifolen[0 +: 5]}, 32'd17);
    check("fill_full0", {31'h0, fifofull[0]}, 32'd1);
    check("fill_ovf_pre", {31'h0, fifoovf[0]}, 32'd0);
    wr(2'd0, 8'h11);
    check("ovf_set", {31'h0, fifoovf[0]}, 32'd1);
    check("ovf_len0", {27'h0, fifolen[0 +: 5]}, 32'd17);
    for (int i = 0; i < 17; i++) begin
      check("pop_dat", {23'h0, notempty[0], fifodout[0 +: 8]}, {23'h0, 1'b1, 8'(i)});
      fiford = 4'b0001;
      step();
    end
    fiford = 0;
    check("pop_empty", {31'h0, notempty[0]}, 32'd0);
    check("pop_len0", {27'h0, fifolen[0 +: 5]}, 32'd0);
    check("pop_udf", {31'h0, fifoudf[0]}, 32'd0);
    errclr = 1'b1; step(); errclr = 1'b0;
    check("errclr_ovf", {28'h0, fifoovf}, 32'h0);

    // Write to a full memory with a simultaneous pop is dropped
    for (int i = 0; i < 17; i++) wr(2'd0, 8'(i));
    fifowr = 1'b1; fifowrch = 0; fifodin = 8'hEE; fiford = 4'b0001;
    step();
    fifowr = 0; fiford = 0;
    check("fullrd_len0", {27'h0, fifolen[0 +: 5]}, 32'd16);
    check("fullrd_ovf", {31'h0, fifoovf[0]}, 32'd1);
    fifoflush = 4'b0001; errclr = 1'b1; step(); fifoflush = 0; errclr = 0;

    // Wrap-around streaming on ch1
    sent = 0; got = 0; cyc = 0;
    while (got < 40 && cyc < 100) begin
      fifowr = (sent < 40); fifowrch = 2'd1; fifodin = 8'(8'h40 + sent);
      fiford = {2'b0, notempty[1], 1'b0};
      if (notempty[1]) begin
        check("stream_dat", {24'h0, fifodout[8 +: 8]}, 32'(8'(8'h40 + got)));
        got++;
      end
      if (sent < 40) sent++;
      step();
      cyc++;
      if (got < 40)
        check("stream_len", {31'h0, (fifolen[5 +: 5] >= 5'd1) && (fifolen[5 +: 5] <= 5'd2)}, 32'd1);
    end
    fifowr = 0; fiford = 0;
    check("stream_got", 32'(got), 32'd40);
    check("stream_cycles", 32'(cyc), 32'd42);
    check("stream_flags", {24'h0, fifoovf, fifoudf}, 32'h0);

    // Almost-full threshold on ch3
    for (int i = 0; i < 11; i++) wr(2'd3, 8'(i));
    check("afull_11", {31'h0, fifoafull[3]}, 32'd0);
    wr(2'd3, 8'hB0);
    check("afull_12", {31'h0, fifoafull[3]}, 32'd1);
    fiford = 4'b1000; step(); fiford = 0;
    check("afull_pop", {31'h0, fifoafull[3]}, 32'd0);
    check("afull_len3", {27'h0, fifolen[15 +: 5]}, 32'd11);
    fifoflush = 4'b1000; step(); fifoflush = 0;

    // Flush priority on ch0
    for (int i = 0; i < 5; i++) wr(2'd0, 8'(8'h10 + i));
    fifoflush = 4'b0001; fifowr = 1'b1; fifowrch = 0; fifodin = 8'h77; fiford = 4'b0001;
    step();
    fifoflush = 0; fifowr = 0; fiford = 0;
    check("flush_len0", {27'h0, fifolen[0 +: 5]}, 32'd0);
    check("flush_ne_dout", {23'h0, notempty[0], fifodout[0 +: 8]}, 32'h0);
    check("flush_flags", {24'h0, fifoovf, fifoudf}, 32'h0);
    wr(2'd0, 8'h3C);
    step();
    check("flush_after", {23'h0, notempty[0], fifodout[0 +: 8]}, 32'h13C);
    check("flush_after_len", {27'h0, fifolen[0 +: 5]}, 32'd1);

    // Underflow and errclr
    fiford = 4'b0010; step(); fiford = 0;
    check("udf_set", {28'h0, fifoudf}, 32'h2);
    errclr = 1'b1; fiford = 4'b0010; step(); fiford = 0;
    check("udf_clr_set", {28'h0, fifoudf}, 32'h2);
    step(); errclr = 1'b0;
    check("udf_clr", {28'h0, fifoudf}, 32'h0);

    // Reset mid-traffic discards data
    wr(2'd2, 8'h55); wr(2'd2, 8'h66);
    rst_ = 1'b0; step(); rst_ = 1'b1;
    check("midrst_len", {12'h0, fifolen}, 32'h0);
    check("midrst_ne", {28'h0, notempty}, 32'h0);

    // Out-of-range channel on the 3-channel instance
    d3_wr = 1'b1; d3_wrch = 2'd3; d3_din = 8'hFF;
    step();
    d3_wr = 1'b0;
    step();
    check("nch3_len", {17'h0, d3_len}, 32'h0);
    check("nch3_ne_ovf", {26'h0, d3_notempty, d3_ovf}, 32'h0);
    d3_wr = 1'b1; d3_wrch = 2'd2; d3_din = 8'h9A;
    step();
    d3_wr = 1'b0;
    step();
    check("nch3_ch2", {23'h0, d3_notempty[2], d3_dout[16 +: 8]}, 32'h19A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
